// File: rtl/alu_op_decoder.sv
// alu_op_decoder: RV32I decode stage emitting one-hot ALU enables behind a registered skid handshake
module alu_op_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             add_en,
  output logic             sub_en,
  output logic             xor_en,
  output logic             or_en,
  output logic             and_en,
  output logic             use_imm,
  output logic             rs1_zero,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [31:0]      imm,
  output logic [2:0]       funct3,
  output logic             we,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             illegal,
  output logic [31:0]      out_pc,
  output logic [CNT_W-1:0] illegal_count
);
  typedef struct packed {
    logic        add_en, sub_en, xor_en, or_en, and_en;
    logic        use_imm, rs1_zero, we, mem_rd, mem_wr, illegal;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm, pc;
  } dec_t;
  dec_t dec, out_q, skid_q;
  logic skid_valid, accept;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic is_op, is_opi, is_ld, is_st, is_lui, r_ok, legal;
  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];
  assign is_op  = op == 7'b0110011;
  assign is_opi = op == 7'b0010011;
  assign is_ld  = op == 7'b0000011;
  assign is_st  = op == 7'b0100011;
  assign is_lui = op == 7'b0110111;
  // register-register forms only accept funct7 = 0, except sub
  assign r_ok = (is_op && f7 == 7'd0) || is_opi;
  always_comb begin
    dec = '0;
    dec.add_en  = (r_ok && f3 == 3'b000) || is_ld || is_st || is_lui;
    dec.sub_en  = is_op && f7 == 7'b0100000 && f3 == 3'b000;
    dec.xor_en  = r_ok && f3 == 3'b100;
    dec.or_en   = r_ok && f3 == 3'b110;
    dec.and_en  = r_ok && f3 == 3'b111;
    legal       = dec.add_en | dec.sub_en | dec.xor_en | dec.or_en | dec.and_en;
    dec.illegal = !legal;
    dec.use_imm = legal && !is_op;
    dec.rs1_zero = is_lui;
    dec.we      = legal && !is_st;
    dec.mem_rd  = is_ld;
    dec.mem_wr  = is_st;
    dec.rd      = in_instr[11:7];
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.funct3  = f3;
    dec.pc      = in_pc;
    dec.imm     = (is_opi || is_ld) ? {{20{in_instr[31]}}, in_instr[31:20]} :
                  is_st ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
                  is_lui ? {in_instr[31:12], 12'd0} : 32'd0;
  end
  assign in_ready = !skid_valid;
  assign accept = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      skid_valid    <= 1'b0;
      out_q         <= '0;
      skid_q        <= '0;
      illegal_count <= '0;
    end else begin
      if (out_valid && out_ready && out_q.illegal && !(&illegal_count))
        illegal_count <= illegal_count + 1'b1;
      if (flush) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
      end else if (!out_valid || out_ready) begin
        out_valid  <= skid_valid || accept;
        skid_valid <= 1'b0;
        if (skid_valid) out_q <= skid_q;
        else if (accept) out_q <= dec;
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_q     <= dec;
      end
    end
  end
  assign add_en   = out_valid & out_q.add_en;
  assign sub_en   = out_valid & out_q.sub_en;
  assign xor_en   = out_valid & out_q.xor_en;
  assign or_en    = out_valid & out_q.or_en;
  assign and_en   = out_valid & out_q.and_en;
  assign we       = out_valid & out_q.we;
  assign mem_rd   = out_valid & out_q.mem_rd;
  assign mem_wr   = out_valid & out_q.mem_wr;
  assign illegal  = out_valid & out_q.illegal;
  assign use_imm  = out_q.use_imm;
  assign rs1_zero = out_q.rs1_zero;
  assign rd       = out_q.rd;
  assign rs1      = out_q.rs1;
  assign rs2      = out_q.rs2;
  assign imm      = out_q.imm;
  assign funct3   = out_q.funct3;
  assign out_pc   = out_q.pc;
endmodule
